// File: rtl/router_fsm.sv
// router_fsm -- control FSM for the 1x3 packet router.
//
// Sequences the register datapath (header / payload / parity capture and
// parity check) and gates writes into the three destination FIFOs. The
// destination address is decoded from the header byte. The FSM stalls on a
// busy or full FIFO. It returns to idle once parity has been checked, or when
// the selected destination soft-resets.
//
// Ports
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset
//   pkt_valid      in   packet in progress; low on the parity byte
//   din[1:0]       in   destination address while in DECODE_ADDRESS
//   fifo_full      in   full flag of the selected FIFO
//   fifo_empty_0-2 in   per-FIFO empty flags
//   soft_reset_0-2 in   per-FIFO read-timeout resets
//   parity_done    in   parity byte captured by the register block
//   low_pkt_valid  in   pkt_valid fell while the FIFO was full
//   detect_addr    out  state is DECODE_ADDRESS
//   lfd_state      out  state is LOAD_FIRST_DATA
//   ld_state       out  state is LOAD_DATA
//   laf_state      out  state is LOAD_AFTER_FULL
//   full_state     out  state is FIFO_FULL_STATE
//   rst_int_reg    out  state is CHECK_PARITY_ERROR
//   write_enb_reg  out  FIFO write enable
//   busy           out  input port must hold the current byte
module router_fsm (
   input  logic       clk,
   input  logic       rst,
   input  logic       pkt_valid,
   input  logic [1:0] din,
   input  logic       fifo_full,
   input  logic       fifo_empty_0,
   input  logic       fifo_empty_1,
   input  logic       fifo_empty_2,
   input  logic       soft_reset_0,
   input  logic       soft_reset_1,
   input  logic       soft_reset_2,
   input  logic       parity_done,
   input  logic       low_pkt_valid,
   output logic       detect_addr,
   output logic       lfd_state,
   output logic       ld_state,
   output logic       laf_state,
   output logic       full_state,
   output logic       rst_int_reg,
   output logic       write_enb_reg,
   output logic       busy
);

   typedef enum logic [2:0] {
      DECODE_ADDRESS     = 3'd0,
      LOAD_FIRST_DATA    = 3'd1,
      LOAD_DATA          = 3'd2,
      LOAD_PARITY        = 3'd3,
      CHECK_PARITY_ERROR = 3'd4,
      FIFO_FULL_STATE    = 3'd5,
      LOAD_AFTER_FULL    = 3'd6,
      WAIT_TILL_EMPTY    = 3'd7
   } state_t;

   state_t     r_state;
   state_t     w_next;
   logic [1:0] r_addr;
   logic [3:0] w_empty_vec;
   logic [3:0] w_soft_vec;
   logic       w_addr_ok;

   // Address 3 has no FIFO. Its slot reads as "not empty, no soft reset".
   assign w_empty_vec = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
   assign w_soft_vec  = {1'b0, soft_reset_2, soft_reset_1, soft_reset_0};
   assign w_addr_ok   = (din != 2'b11);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= DECODE_ADDRESS;
         r_addr  <= '0;
      end else begin
         r_state <= w_next;
         if (r_state == DECODE_ADDRESS && pkt_valid)
            r_addr <= din;
      end
   end

   always_comb begin
      w_next = r_state;
      if (r_state != DECODE_ADDRESS && w_soft_vec[r_addr]) begin
         // A soft reset from the selected destination overrides every transition.
         w_next = DECODE_ADDRESS;
      end else begin
         unique case (r_state)
            DECODE_ADDRESS: begin
               if (pkt_valid && w_addr_ok)
                  w_next = w_empty_vec[din] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
            end
            LOAD_FIRST_DATA: w_next = LOAD_DATA;
            LOAD_DATA: begin
               if (fifo_full)
                  w_next = FIFO_FULL_STATE;
               else if (!pkt_valid)
                  w_next = LOAD_PARITY;
            end
            LOAD_PARITY: w_next = CHECK_PARITY_ERROR;
            CHECK_PARITY_ERROR:
               w_next = fifo_full ? FIFO_FULL_STATE : DECODE_ADDRESS;
            FIFO_FULL_STATE: begin
               if (!fifo_full)
                  w_next = LOAD_AFTER_FULL;
            end
            LOAD_AFTER_FULL: begin
               if (parity_done)
                  w_next = DECODE_ADDRESS;
               else if (low_pkt_valid)
                  w_next = LOAD_PARITY;
               else
                  w_next = LOAD_DATA;
            end
            WAIT_TILL_EMPTY: begin
               if (w_empty_vec[r_addr])
                  w_next = LOAD_FIRST_DATA;
            end
            default: w_next = DECODE_ADDRESS;
         endcase
      end
   end

   always_comb begin
      detect_addr   = (r_state == DECODE_ADDRESS);
      lfd_state     = (r_state == LOAD_FIRST_DATA);
      ld_state      = (r_state == LOAD_DATA);
      laf_state     = (r_state == LOAD_AFTER_FULL);
      full_state    = (r_state == FIFO_FULL_STATE);
      rst_int_reg   = (r_state == CHECK_PARITY_ERROR);
      write_enb_reg = (r_state == LOAD_FIRST_DATA) || (r_state == LOAD_DATA) ||
                      (r_state == LOAD_PARITY)     || (r_state == LOAD_AFTER_FULL);
      busy          = !((r_state == DECODE_ADDRESS) || (r_state == LOAD_DATA));
   end

endmodule

// File: doc/router_fsm.md
# router_fsm

Control FSM for the 1x3 packet router. It sequences the `register` datapath block (header/payload/parity capture and parity check) and gates writes into the three destination FIFOs. It decodes the destination address from the header byte, stalls on busy or full FIFOs, and returns to idle after parity is checked or a destination soft-resets. It sits between the input port, the `register` block, the FIFO synchronizer and the three output FIFOs.

## Interface
- No parameters.
- `clk` in 1: system clock, all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `pkt_valid` in 1: input packet in progress; deasserts on the parity byte.
- `din` in 2: `din[1:0]` of the input byte, the destination address during header.
- `fifo_full` in 1: full flag of the currently selected FIFO, from the synchronizer.
- `fifo_empty_0`, `fifo_empty_1`, `fifo_empty_2` in 1 each: per-FIFO empty flags.
- `soft_reset_0`, `soft_reset_1`, `soft_reset_2` in 1 each: per-FIFO read-timeout resets.
- `parity_done` in 1: from `register`; the parity byte has been captured.
- `low_pkt_valid` in 1: from `register`; `pkt_valid` fell while the FIFO was full.
- `detect_addr` out 1: state is DECODE_ADDRESS.
- `lfd_state` out 1: state is LOAD_FIRST_DATA.
- `ld_state` out 1: state is LOAD_DATA.
- `laf_state` out 1: state is LOAD_AFTER_FULL.
- `full_state` out 1: state is FIFO_FULL_STATE.
- `rst_int_reg` out 1: state is CHECK_PARITY_ERROR.
- `write_enb_reg` out 1: FIFO write enable.
- `busy` out 1: input port must hold the current byte.

## Operation
- Eight states, binary-encoded: DECODE_ADDRESS (DA), LOAD_FIRST_DATA (LFD), LOAD_DATA (LD), LOAD_PARITY (LP), CHECK_PARITY_ERROR (CPE), FIFO_FULL_STATE (FFS), LOAD_AFTER_FULL (LAF), WAIT_TILL_EMPTY (WTE).
- Address latch `addr[1:0]` loads `din` in DA when `pkt_valid` is high. The address is valid only if `din` is not 2'b11.
- Transitions, with conditions sampled at the clock edge:
  - DA: on `pkt_valid` with a valid address, go to LFD if `fifo_empty[din]` is high, otherwise to WTE. Otherwise stay in DA; address 3 is ignored.
  - LFD: always go to LD.
  - LD: go to FFS if `fifo_full` is high. Otherwise go to LP if `pkt_valid` is low. Otherwise stay in LD.
  - LP: always go to CPE.
  - CPE: go to FFS if `fifo_full` is high, otherwise to DA.
  - FFS: go to LAF when `fifo_full` is low, otherwise stay.
  - LAF: go to DA if `parity_done` is high. Otherwise go to LP if `low_pkt_valid` is high. Otherwise go to LD.
  - WTE: go to LFD when `fifo_empty[addr]` is high, otherwise stay.
- Soft reset: `soft_reset[addr]` high in any state other than DA forces DA on the next edge. This has priority over every transition except `rst`. Soft resets of non-selected FIFOs are ignored.
- Outputs are Moore, decoded from the state register only:
  - `write_enb_reg` = LFD | LD | LP | LAF.
  - `busy` = LFD | LP | CPE | FFS | LAF | WTE. It is low in DA and LD.
- Reset and mid-packet reset:
  - `rst` high forces DA and clears `addr` to 0, with priority over everything.
  - Reset values: `detect_addr` = 1; all other outputs 0.
  - A reset mid-packet abandons the packet. The datapath resynchronizes on the next `pkt_valid` in DA.

## Timing
- State register plus combinational next-state logic. Outputs change one cycle after the condition is sampled.
- Header handshake:
  - Header is present with `pkt_valid` high in cycle N while in DA.
  - If the FIFO is empty, the state is LFD in N+1, which asserts `lfd_state`, `write_enb_reg` and `busy`.
  - The state is LD in N+2.
  - The input port must hold the header byte while `busy` is high.
- Parity handshake:
  - `pkt_valid` low in LD at cycle M.
  - LP at M+1, where the parity byte is written.
  - CPE at M+2, which asserts `rst_int_reg` for exactly one cycle.
  - DA at M+3.
- Full stall: in FFS, `write_enb_reg` is 0. Leaving FFS always passes through LAF for exactly one cycle to write the held byte.

## Test plan
- Address 2'b01 with `fifo_empty_1` = 1, 8 payload bytes, then parity → required sequence DA,LFD,LD×8,LP,CPE,DA. `write_enb_reg` is high for 10 cycles. `rst_int_reg` pulses once.
- Address 2'b10 with `fifo_empty_2` = 0 for 5 cycles → WTE with `busy` = 1 for those 5 cycles. Then `fifo_empty_2` = 1 → LFD on the next edge.
- `fifo_full` = 1 on the 3rd LD cycle for 4 cycles → FFS for 4 cycles with `write_enb_reg` = 0. Then LAF once with `parity_done` = 0 and `low_pkt_valid` = 0, then back to LD.
- `fifo_full` rises during LD while `pkt_valid` falls, so `low_pkt_valid` = 1 → FFS, LAF, LP, CPE, DA.
- Header `din` = 2'b11 with `pkt_valid` = 1 → remains in DA with `detect_addr` = 1 and `busy` = 0.
- `soft_reset_1` pulsed in LD (addr 1) → DA next cycle. `soft_reset_0` pulsed in LD (addr 1) → no effect. `rst` = 1 in LP → DA with reset output values next edge.
